// File: rtl/sign_truncator_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sign_truncator_if
// Description : Request/result handshake bundle for the sign truncator.
// Revision    : 1.0 - initial release
// ============================================================================
interface sign_truncator_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  msb_num;
    logic        shift_first;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_field;
    logic        out_ovf;
    logic        out_misalign;

    modport master (
        output in_valid, in_data, msb_num, shift_first, out_ready,
        input  in_ready, out_valid, out_field, out_ovf, out_misalign
    );

    modport slave (
        input  in_valid, in_data, msb_num, shift_first, out_ready,
        output in_ready, out_valid, out_field, out_ovf, out_misalign
    );
endinterface
`default_nettype wire

// File: rtl/sign_truncator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sign_truncator
// Description : Narrows a 16-bit signed value into an N-bit field, with
//               optional halving, overflow/misalign flags and error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sign_truncator #(
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    sign_truncator_if.slave       bus,
    input  wire logic             err_clr,
    output logic [CNT_W-1:0]      err_count
);

    localparam logic [CNT_W-1:0] C_ERR_MAX = '1;

    logic        r_s1_valid;
    logic [15:0] r_s1_v;
    logic [3:0]  r_s1_msb;
    logic        r_s1_mis;

    logic        r_s2_valid;
    logic [15:0] r_field;
    logic        r_ovf;
    logic        r_mis;

    logic [CNT_W-1:0] r_err;

    logic        w_s2_adv;
    logic        w_s1_adv;
    logic [15:0] w_aligned;
    logic [15:0] w_hi_mask;
    logic [15:0] w_hi_bits;
    logic        w_ovf;
    logic [15:0] w_field;
    logic        w_err_evt;

    assign w_s2_adv = !r_s2_valid || bus.out_ready;
    assign w_s1_adv = w_s2_adv || !r_s1_valid;

    assign w_aligned = bus.shift_first ? {bus.in_data[15], bus.in_data[15:1]}
                                       : bus.in_data;

    // The value fits when every bit from the field MSB upward is a copy of the sign.
    assign w_hi_mask = 16'hFFFF << r_s1_msb;
    assign w_hi_bits = r_s1_v & w_hi_mask;
    assign w_ovf     = !((w_hi_bits == 16'h0000) || (w_hi_bits == w_hi_mask));
    assign w_field   = r_s1_v & (16'hFFFF >> (4'd15 - r_s1_msb));

    assign w_err_evt = r_s2_valid && bus.out_ready && (r_ovf || r_mis);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_v     <= 16'h0000;
            r_s1_msb   <= 4'd0;
            r_s1_mis   <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_v   <= w_aligned;
                r_s1_msb <= bus.msb_num;
                r_s1_mis <= bus.shift_first & bus.in_data[0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_field    <= 16'h0000;
            r_ovf      <= 1'b0;
            r_mis      <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_field <= w_field;
                r_ovf   <= w_ovf;
                r_mis   <= r_s1_mis;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= '0;
        end else if (err_clr) begin
            r_err <= '0;
        end else if (w_err_evt && (r_err != C_ERR_MAX)) begin
            r_err <= r_err + 1'b1;
        end
    end

    assign bus.in_ready     = w_s1_adv;
    assign bus.out_valid    = r_s2_valid;
    assign bus.out_field    = r_field;
    assign bus.out_ovf      = r_ovf;
    assign bus.out_misalign = r_mis;
    assign err_count        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sign_truncator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sign_truncator
// Description : Directed bench with an arithmetic reference model and scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sign_truncator;

    localparam int CNT_W = 8;

    typedef struct {
        logic [15:0] field;
        logic        ovf;
        logic        mis;
        logic [15:0] din;
        logic [3:0]  msb;
        logic        sh;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             err_clr;
    logic [CNT_W-1:0] err_count;

    sign_truncator_if bus_if ();

    sign_truncator #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .err_clr   (err_clr),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          m_err = 0;
    exp_t        q[$];
    logic [15:0] emitted[$];
    logic        bp_en = 1'b0;
    logic        hold_prev = 1'b0;
    logic [15:0] p_field;
    logic        p_ovf;
    logic        p_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer range test and modulo, independent of bit slicing.
    function automatic exp_t model(input logic [15:0] d, input logic [3:0] m, input logic sh);
        exp_t e;
        int   s;
        int   lim;
        s = int'($signed(d));
        if (sh) s = s >>> 1;
        lim     = 1 << m;
        e.ovf   = (s < -lim) || (s >= lim);
        e.field = 16'(s & ((1 << (int'(m) + 1)) - 1));
        e.mis   = sh & d[0];
        e.din   = d;
        e.msb   = m;
        e.sh    = sh;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t        e;
        int          rt;
        logic [31:0] rtv;
        if (!rst_n) begin
            q.delete();
            m_err     = 0;
            hold_prev = 1'b0;
        end else begin
            chk("err_count", 32'(err_count), 32'(m_err));
            if (hold_prev) begin
                chk("hold_field", 32'(bus_if.out_field), 32'(p_field));
                chk("hold_ovf", 32'(bus_if.out_ovf), 32'(p_ovf));
                chk("hold_mis", 32'(bus_if.out_misalign), 32'(p_mis));
                chk("hold_valid", 32'(bus_if.out_valid), 32'd1);
            end
            if (bus_if.out_valid && bus_if.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("out_field", 32'(bus_if.out_field), 32'(e.field));
                    chk("out_ovf", 32'(bus_if.out_ovf), 32'(e.ovf));
                    chk("out_mis", 32'(bus_if.out_misalign), 32'(e.mis));
                    if (!e.ovf && !e.mis) begin
                        rt = int'(bus_if.out_field);
                        if (bus_if.out_field[e.msb]) rt = rt - (1 << (int'(e.msb) + 1));
                        if (e.sh) rt = rt * 2;
                        rtv = 32'(rt);
                        chk("roundtrip", 32'(rtv[15:0]), 32'(e.din));
                    end
                    emitted.push_back(bus_if.out_field);
                    if (e.ovf || e.mis)
                        m_err = (m_err < (1 << CNT_W) - 1) ? m_err + 1 : m_err;
                end
            end
            if (err_clr) m_err = 0;
            hold_prev = bus_if.out_valid && !bus_if.out_ready;
            p_field   = bus_if.out_field;
            p_ovf     = bus_if.out_ovf;
            p_mis     = bus_if.out_misalign;
            if (bus_if.in_valid && bus_if.in_ready)
                q.push_back(model(bus_if.in_data, bus_if.msb_num, bus_if.shift_first));
        end
    end

    // Returns #1 after the accepting edge.
    task automatic send(input logic [15:0] d, input logic [3:0] m, input logic sh);
        bus_if.in_valid    = 1'b1;
        bus_if.in_data     = d;
        bus_if.msb_num     = m;
        bus_if.shift_first = sh;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus_if.in_ready) begin
                @(posedge clk);
                #1;
                bus_if.in_valid = 1'b0;
                if (bp_en) bus_if.out_ready = 1'($urandom_range(0, 1));
                return;
            end
            @(posedge clk);
            #1;
            if (bp_en) bus_if.out_ready = ~bus_if.out_ready;
        end
        chk("send_timeout", 32'd1, 32'd0);
        bus_if.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus_if.out_valid && q.size() == 0) return;
        end
        chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic single(input logic [15:0] d, input logic [3:0] m, input logic sh,
                          input logic [15:0] ef, input logic eo, input logic em,
                          input int eerr);
        wait_idle();
        @(posedge clk);
        #1;
        send(d, m, sh);
        chk("lat1_valid", 32'(bus_if.out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat2_valid", 32'(bus_if.out_valid), 32'd1);
        chk("lit_field", 32'(bus_if.out_field), 32'(ef));
        chk("lit_ovf", 32'(bus_if.out_ovf), 32'(eo));
        chk("lit_mis", 32'(bus_if.out_misalign), 32'(em));
        @(posedge clk);
        #1;
        chk("lit_err", 32'(err_count), 32'(eerr));
    endtask

    logic [15:0] tbl_d[8] = '{16'h7FFF, 16'h0003, 16'hFFFF, 16'h0000,
                              16'hFF80, 16'hFF7F, 16'h00FF, 16'h8001};
    logic [3:0]  tbl_m[8] = '{4'd15, 4'd0, 4'd0, 4'd0, 4'd7, 4'd7, 4'd7, 4'd14};
    logic        tbl_s[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int n0;
        rst_n              = 1'b0;
        err_clr            = 1'b0;
        bus_if.in_valid    = 1'b0;
        bus_if.in_data     = 16'h0000;
        bus_if.msb_num     = 4'd0;
        bus_if.shift_first = 1'b0;
        bus_if.out_ready   = 1'b1;
        #1;
        chk("rst_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst_field", 32'(bus_if.out_field), 32'd0);
        chk("rst_ovf", 32'(bus_if.out_ovf), 32'd0);
        chk("rst_mis", 32'(bus_if.out_misalign), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        #11;
        rst_n = 1'b1;

        single(16'hFFF6, 4'd9, 1'b1, 16'h03FB, 1'b0, 1'b0, 0);
        single(16'h0400, 4'd9, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
        single(16'h0007, 4'd3, 1'b1, 16'h0003, 1'b0, 1'b1, 2);
        single(16'h8000, 4'd15, 1'b0, 16'h8000, 1'b0, 1'b0, 2);

        // Backpressure: two accepted, third blocked while outputs hold.
        wait_idle();
        @(posedge clk);
        #1;
        n0 = emitted.size();
        bus_if.out_ready   = 1'b0;
        bus_if.in_valid    = 1'b1;
        bus_if.msb_num     = 4'd7;
        bus_if.shift_first = 1'b0;
        bus_if.in_data     = 16'h0001;
        @(negedge clk);
        chk("bp_rdy1", 32'(bus_if.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus_if.in_data = 16'h0002;
        @(negedge clk);
        chk("bp_rdy2", 32'(bus_if.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus_if.in_data = 16'h0003;
        repeat (3) begin
            @(negedge clk);
            chk("bp_rdy3", 32'(bus_if.in_ready), 32'd0);
            chk("bp_hold", 32'(bus_if.out_field), 32'h0001);
        end
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rdy4", 32'(bus_if.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        wait_idle();
        chk("bp_count", 32'(emitted.size() - n0), 32'd3);
        if (emitted.size() - n0 == 3) begin
            chk("bp_ord0", 32'(emitted[n0]), 32'h0001);
            chk("bp_ord1", 32'(emitted[n0+1]), 32'h0002);
            chk("bp_ord2", 32'(emitted[n0+2]), 32'h0003);
        end

        // Table, streamed at full rate then with random backpressure.
        for (int i = 0; i < 8; i++) send(tbl_d[i], tbl_m[i], tbl_s[i]);
        wait_idle();
        bp_en = 1'b1;
        for (int i = 0; i < 8; i++) send(tbl_d[i], tbl_m[i], tbl_s[i]);
        bp_en = 1'b0;
        wait_idle();

        for (int i = 0; i < 300; i++) send(16'h0400, 4'd9, 1'b0);
        wait_idle();
        chk("err_sat", 32'(err_count), 32'd255);

        // Clear on the same cycle as an erroring handshake.
        @(posedge clk);
        #1;
        send(16'h0400, 4'd9, 1'b0);
        @(posedge clk);
        #1;
        chk("clr_valid", 32'(bus_if.out_valid), 32'd1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("clr_err", 32'(err_count), 32'd0);

        // Reset with both stages full.
        wait_idle();
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        send(16'h0011, 4'd7, 1'b0);
        send(16'h0022, 4'd7, 1'b0);
        chk("full_valid", 32'(bus_if.out_valid), 32'd1);
        chk("full_ready", 32'(bus_if.in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus_if.out_valid), 32'd0);
        chk("arst_field", 32'(bus_if.out_field), 32'd0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        bus_if.out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("stale_out", 32'(bus_if.out_valid), 32'd0);
        end
        single(16'hFFF6, 4'd9, 1'b1, 16'h03FB, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sign_truncator.md
Name: sign_truncator

Overview:
- Inverse of the immediate sign extender: narrows a 16-bit signed value into an N-bit two's-complement instruction field.
- Optionally halves the value first, for word-aligned branch offsets.
- Flags values that do not fit the field (overflow) and odd values when halving (misalign).
- Sits in the instruction-encode path of the monitor/loader: 2-stage valid/ready pipeline with a saturating error counter.

Parameters:
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_data  input  16  signed value to encode.
- msb_num  input  4  bit index of the field MSB (field width = msb_num+1).
- shift_first  input  1  arithmetic shift right by 1 before truncation.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed when out_valid && out_ready.
- out_field  output  16  bits [msb_num:0] of the aligned value; bits above msb_num are zero.
- out_ovf  output  1  aligned value not representable in msb_num+1 bits.
- out_misalign  output  1  shift_first=1 and in_data[0]=1.
- err_clr  input  1  synchronous clear of err_count.
- err_count  output  CNT_W  results with ovf or misalign, saturating.

Behaviour:
- Reset (async, rst_n low):
  - s1_valid, s2_valid, out_valid = 0.
  - out_field = 0, out_ovf = 0, out_misalign = 0, err_count = 0.
  - Reset mid-operation discards all in-flight data; nothing is emitted afterwards.
- Stage 1, registered on accept:
  - v = shift_first ? {in_data[15], in_data[15:1]} : in_data.
  - misalign = shift_first & in_data[0].
  - msb_num is captured with v.
- Stage 2, registered:
  - ovf = 1 unless bits v[15:msb_num] are all 0 or all 1. msb_num=15 never overflows.
  - out_field = v & (16'hFFFF >> (15-msb_num)). The field is produced even on ovf.
- Latency and throughput:
  - Exactly 2 cycles from accept to out_valid when unstalled.
  - Throughput 1 per cycle.
- Flow control:
  - s2 advances when !s2_valid || out_ready.
  - s1 advances when s2 advances or !s1_valid.
  - in_ready = !s1_valid || s2 advances (combinational from out_ready).
  - Holding capacity 2; no data lost or reordered under backpressure.
- Output stability: while out_valid && !out_ready, out_field, out_ovf and out_misalign hold stable.
- Round-trip invariant: if ovf=0 and misalign=0, sign-extending out_field at msb_num (and left-shifting when shift_first) reproduces in_data exactly.
- err_count:
  - Increments on an output handshake with (ovf|misalign).
  - Saturates at 2^CNT_W-1.
  - err_clr has priority over a same-cycle increment; the result is 0.
- Inputs are don't-care when in_valid=0.

Test Plan:
- in_data=0xFFF6, msb_num=9, shift_first=1, out_ready=1 -> out_valid exactly 2 cycles after accept; out_field=0x03FB, ovf=0, misalign=0.
- in_data=0x0400, msb_num=9, shift_first=0 -> out_field=0x0000, ovf=1; err_count increments 0->1 on handshake.
- in_data=0x0007, msb_num=3, shift_first=1 -> out_field=0x0003, misalign=1, ovf=0.
- in_data=0x8000, msb_num=15, shift_first=0 -> out_field=0x8000, ovf=0.
- Backpressure: out_ready=0, offer 0x0001/0x0002/0x0003 (msb_num=7) back-to-back:
  - Two are accepted, then in_ready=0 with outputs stable.
  - Raise out_ready -> 0x01, 0x02, 0x03 emitted in order.
- Counter edges:
  - 300 overflowing requests -> err_count=255.
  - err_clr asserted on a cycle with an erroring handshake -> 0.
- Reset:
  - Assert rst_n low with both stages full -> out_valid=0 immediately.
  - After release, no stale result appears.
